rominit_router: RTL and testbench

- Next-generation ROM download manager for the SCV core. It generalises fixed two-target (boot/chr) routing to NUM_TGT address-windowed targets.
- Sits between hps_io ioctl signals and the on-chip ROM/RAM loaders.
- Decodes each downloaded byte to a target window and buffers it in a small FIFO.
- Delivers bytes over a valid/ready handshake, applies ioctl back-pressure, and reports per-target completion and routing errors.

---
 rtl/rominit_router.sv | 206 ++++++++++++++++++++
 tb/tb_rominit_router.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rominit_router.sv
// ROM download router: decodes ioctl bytes to NUM_TGT windows, buffers them and hands them out on valid/ready (optional ROMINIT_ROUTER_CHECKSUM_EN adds ROMINIT_SUM).
// Latency 1 clk strobe->VALID through the empty-FIFO bypass; IOCTL_WAIT rises one entry early so an in-flight strobe still fits.

module rominit_router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;

  assign head_dat = mem[rd_ptr];
  assign empty    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module rominit_router #(
  parameter int                    NUM_TGT    = 2,
  parameter int                    AW         = 13,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [7:0]            IMG_INDEX  = 8'd0,
  parameter logic [25*NUM_TGT-1:0] TGT_BASE   = {25'h1000, 25'h0},
  parameter logic [(AW+1)*NUM_TGT-1:0] TGT_SIZE = {14'h2000, 14'h1000}
) (
  input  logic               CLK_SYS,
  input  logic               RESET,
  input  logic               IOCTL_DOWNLOAD,
  input  logic [7:0]         IOCTL_INDEX,
  input  logic               IOCTL_WR,
  input  logic [24:0]        IOCTL_ADDR,
  input  logic [7:0]         IOCTL_DOUT,
  output logic               IOCTL_WAIT,
  output logic [NUM_TGT-1:0] ROMINIT_SEL,
  output logic [AW-1:0]      ROMINIT_ADDR,
  output logic [7:0]         ROMINIT_DATA,
  output logic               ROMINIT_VALID,
  input  logic               ROMINIT_READY,
  output logic [NUM_TGT-1:0] ROMINIT_DONE,
  output logic               ROMINIT_BUSY,
`ifdef ROMINIT_ROUTER_CHECKSUM_EN
  output logic [15:0]        ROMINIT_SUM,
`endif
  output logic               ROMINIT_ERR
);
  localparam int TW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TW-1:0] tgt;
    logic [AW-1:0] addr;
    logic [7:0]    dat;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t        state_q, state_next;
  logic [CW-1:0] occ_q, occ_next;
  logic [AW:0]   cnt_q [NUM_TGT];

  logic          hit;
  logic [TW-1:0] hit_tgt;
  logic [AW-1:0] hit_off;
  entry_t        new_ent, fifo_head;
  logic          fifo_empty, fifo_push, fifo_pop;
  logic          wr_req, xfer, accept, out_ld, bypass, start;

  // Scan high-to-low so the lowest matching window wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_tgt = '0;
    hit_off = '0;
    for (int t = NUM_TGT - 1; t >= 0; t--) begin
      if ({1'b0, IOCTL_ADDR} >= {1'b0, TGT_BASE[25*t +: 25]} &&
          {1'b0, IOCTL_ADDR} < ({1'b0, TGT_BASE[25*t +: 25]} + 26'(TGT_SIZE[(AW+1)*t +: AW+1]))) begin
        hit     = 1'b1;
        hit_tgt = TW'(t);
        hit_off = AW'(IOCTL_ADDR - TGT_BASE[25*t +: 25]);
      end
    end
  end

  assign new_ent = '{tgt: hit_tgt, addr: hit_off, dat: IOCTL_DOUT};

  // The output register counts as one occupancy slot; a slot freed by a
  // same-cycle transfer may be reused immediately.
  assign wr_req    = (state_q == LOAD) && IOCTL_WR;
  assign xfer      = ROMINIT_VALID && ROMINIT_READY;
  assign accept    = wr_req && hit && ((occ_q != CW'(FIFO_DEPTH)) || xfer);
  assign out_ld    = !ROMINIT_VALID || xfer;
  assign fifo_pop  = out_ld && !fifo_empty;
  assign bypass    = out_ld && fifo_empty && accept;
  assign fifo_push = accept && !bypass;
  assign occ_next  = occ_q + CW'(accept) - CW'(xfer);

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (IOCTL_DOWNLOAD && (IOCTL_INDEX == IMG_INDEX)) state_next = LOAD;
      LOAD:    if (!IOCTL_DOWNLOAD) state_next = DRAIN;
      DRAIN:   if (occ_q == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign start        = (state_q == IDLE) && (state_next == LOAD);
  assign ROMINIT_BUSY = (state_q != IDLE);

  rominit_router_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (CLK_SYS),
    .rst      (RESET),
    .push     (fifo_push),
    .push_dat (new_ent),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      IOCTL_WAIT    <= 1'b0;
      ROMINIT_VALID <= 1'b0;
      ROMINIT_SEL   <= '0;
      ROMINIT_ADDR  <= '0;
      ROMINIT_DATA  <= '0;
      ROMINIT_DONE  <= '0;
      ROMINIT_ERR   <= 1'b0;
      for (int t = 0; t < NUM_TGT; t++) cnt_q[t] <= '0;
    end else begin
      state_q    <= state_next;
      occ_q      <= occ_next;
      IOCTL_WAIT <= (occ_next >= CW'(FIFO_DEPTH - 1)) || (state_next == DRAIN);

      if (out_ld) begin
        if (!fifo_empty) begin
          ROMINIT_VALID <= 1'b1;
          ROMINIT_SEL   <= NUM_TGT'(1) << fifo_head.tgt;
          ROMINIT_ADDR  <= fifo_head.addr;
          ROMINIT_DATA  <= fifo_head.dat;
        end else if (accept) begin
          ROMINIT_VALID <= 1'b1;
          ROMINIT_SEL   <= NUM_TGT'(1) << new_ent.tgt;
          ROMINIT_ADDR  <= new_ent.addr;
          ROMINIT_DATA  <= new_ent.dat;
        end else begin
          ROMINIT_VALID <= 1'b0;
          ROMINIT_SEL   <= '0;
        end
      end

      if (start) begin
        ROMINIT_DONE <= '0;
        ROMINIT_ERR  <= 1'b0;
        for (int t = 0; t < NUM_TGT; t++) cnt_q[t] <= '0;
      end else begin
        if (wr_req && !accept) ROMINIT_ERR <= 1'b1;
        if (xfer) begin
          for (int t = 0; t < NUM_TGT; t++) begin
            if (ROMINIT_SEL[t] && (cnt_q[t] != TGT_SIZE[(AW+1)*t +: AW+1])) begin
              cnt_q[t] <= cnt_q[t] + (AW+1)'(1);
              if ((cnt_q[t] + (AW+1)'(1)) == TGT_SIZE[(AW+1)*t +: AW+1]) ROMINIT_DONE[t] <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef ROMINIT_ROUTER_CHECKSUM_EN
  always_ff @(posedge CLK_SYS) begin
    if (RESET || start) ROMINIT_SUM <= '0;
    else if (xfer)      ROMINIT_SUM <= ROMINIT_SUM + {8'h00, ROMINIT_DATA};
  end
`endif
endmodule

// File: tb/tb_rominit_router.sv
// Directed bench for rominit_router with default parameters.
module tb_rominit_router;
  logic        CLK_SYS = 1'b0;
  logic        RESET = 1'b1;
  logic        IOCTL_DOWNLOAD = 1'b0;
  logic [7:0]  IOCTL_INDEX = 8'd0;
  logic        IOCTL_WR = 1'b0;
  logic [24:0] IOCTL_ADDR = '0;
  logic [7:0]  IOCTL_DOUT = '0;
  logic        IOCTL_WAIT;
  logic [1:0]  ROMINIT_SEL;
  logic [12:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        ROMINIT_READY = 1'b0;
  logic [1:0]  ROMINIT_DONE;
  logic        ROMINIT_BUSY;
  logic        ROMINIT_ERR;
`ifdef ROMINIT_ROUTER_CHECKSUM_EN
  logic [15:0] ROMINIT_SUM;
`endif

  int tests = 0;
  int fails = 0;

  rominit_router dut (
    .CLK_SYS(CLK_SYS), .RESET(RESET),
    .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX), .IOCTL_WR(IOCTL_WR),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT), .IOCTL_WAIT(IOCTL_WAIT),
    .ROMINIT_SEL(ROMINIT_SEL), .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID), .ROMINIT_READY(ROMINIT_READY), .ROMINIT_DONE(ROMINIT_DONE),
    .ROMINIT_BUSY(ROMINIT_BUSY),
`ifdef ROMINIT_ROUTER_CHECKSUM_EN
    .ROMINIT_SUM(ROMINIT_SUM),
`endif
    .ROMINIT_ERR(ROMINIT_ERR)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  task automatic tick;
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 8 && ROMINIT_BUSY; k++) tick();
    tests++;
    if (ROMINIT_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: BUSY=%b, wanted 0 within 8 cycles", name, ROMINIT_BUSY);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) tick();
    tests++;
    if ({ROMINIT_VALID, IOCTL_WAIT, ROMINIT_BUSY, ROMINIT_ERR} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: valid/wait/busy/err=%b, wanted 0000",
               {ROMINIT_VALID, IOCTL_WAIT, ROMINIT_BUSY, ROMINIT_ERR});
    end
    tests++;
    if ({ROMINIT_SEL, ROMINIT_DONE, ROMINIT_ADDR, ROMINIT_DATA} !== 25'd0) begin
      fails++;
      $display("FAIL reset_data: sel=%b done=%b addr=%h data=%h, wanted all 0",
               ROMINIT_SEL, ROMINIT_DONE, ROMINIT_ADDR, ROMINIT_DATA);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic_load;
    int bad, first_i;
    logic [1:0]  esel;
    logic [12:0] eaddr;
    logic [15:0] esum;
    logic [23:0] first_obs;
    bad = 0; first_i = -1; esum = 16'h0; first_obs = '0;
    ROMINIT_READY = 1'b1; IOCTL_INDEX = 8'd0; IOCTL_DOWNLOAD = 1'b1;
    tick();
    tests++;
    if (ROMINIT_BUSY !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: BUSY=%b, wanted 1", ROMINIT_BUSY);
    end
    for (int i = 0; i <= 12288; i++) begin
      if (i < 12288) begin
        IOCTL_WR = 1'b1; IOCTL_ADDR = 25'(i); IOCTL_DOUT = 8'hA5;
      end else begin
        IOCTL_WR = 1'b0; IOCTL_DOWNLOAD = 1'b0;
      end
      tick();
      if (i < 12288) begin
        esel  = (i < 4096) ? 2'b01 : 2'b10;
        eaddr = (i < 4096) ? 13'(i) : 13'(i - 4096);
        esum  = esum + 16'h00A5;
        if (ROMINIT_VALID !== 1'b1 || ROMINIT_SEL !== esel || ROMINIT_ADDR !== eaddr ||
            ROMINIT_DATA !== 8'hA5 || IOCTL_WAIT !== 1'b0) begin
          if (bad == 0) begin
            first_i = i;
            first_obs = {ROMINIT_VALID, IOCTL_WAIT, ROMINIT_SEL, ROMINIT_ADDR[11:0], ROMINIT_DATA};
          end
          bad++;
        end
      end
      if (i == 4095) begin
        tests++;
        if (ROMINIT_DONE !== 2'b00) begin
          fails++;
          $display("FAIL basic_done_before: DONE=%b, wanted 00", ROMINIT_DONE);
        end
      end
      if (i == 4096) begin
        tests++;
        if (ROMINIT_DONE !== 2'b01) begin
          fails++;
          $display("FAIL basic_done0: DONE=%b, wanted 01", ROMINIT_DONE);
        end
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL basic_stream: %0d bad beats, first at byte %0d (valid,wait,sel,addr,data=%h), wanted 0 bad",
               bad, first_i, first_obs);
    end
    tests++;
    if (ROMINIT_DONE !== 2'b11 || ROMINIT_ERR !== 1'b0 || ROMINIT_VALID !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: done=%b err=%b valid=%b, wanted 11/0/0",
               ROMINIT_DONE, ROMINIT_ERR, ROMINIT_VALID);
    end
    wait_idle("basic");
`ifdef ROMINIT_ROUTER_CHECKSUM_EN
    tests++;
    if (ROMINIT_SUM !== esum) begin
      fails++;
      $display("FAIL basic_sum: SUM=%h, wanted %h", ROMINIT_SUM, esum);
    end
`endif
  endtask

  task automatic test_wrong_index;
    int seen;
    seen = 0;
    ROMINIT_READY = 1'b1; IOCTL_INDEX = 8'd1; IOCTL_DOWNLOAD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      IOCTL_WR = 1'b1; IOCTL_ADDR = 25'(k); IOCTL_DOUT = 8'(k);
      tick();
      if (ROMINIT_VALID !== 1'b0 || ROMINIT_BUSY !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL wrongidx_quiet: %0d cycles with VALID or BUSY set, wanted 0", seen);
    end
    tests++;
    if (ROMINIT_DONE !== 2'b11 || ROMINIT_ERR !== 1'b0) begin
      fails++;
      $display("FAIL wrongidx_keep: done=%b err=%b, wanted 11/0", ROMINIT_DONE, ROMINIT_ERR);
    end
    IOCTL_WR = 1'b0; IOCTL_DOWNLOAD = 1'b0; IOCTL_INDEX = 8'd0;
    tick();
  endtask

  task automatic test_backpressure;
    logic [24:0] a [4];
    logic [7:0]  d [4];
    logic [1:0]  s [4];
    logic [12:0] o [4];
    int unstable;
    a[0] = 25'h0FFF; d[0] = 8'h11; s[0] = 2'b01; o[0] = 13'h0FFF;
    a[1] = 25'h1000; d[1] = 8'h22; s[1] = 2'b10; o[1] = 13'h0000;
    a[2] = 25'h2FFF; d[2] = 8'h33; s[2] = 2'b10; o[2] = 13'h1FFF;
    a[3] = 25'h0000; d[3] = 8'h44; s[3] = 2'b01; o[3] = 13'h0000;
    unstable = 0;
    ROMINIT_READY = 1'b0; IOCTL_DOWNLOAD = 1'b1; IOCTL_WR = 1'b0;
    tick();
    tests++;
    if (ROMINIT_DONE !== 2'b00) begin
      fails++;
      $display("FAIL bp_done_clear: DONE=%b, wanted 00", ROMINIT_DONE);
    end
    for (int k = 0; k < 4; k++) begin
      IOCTL_WR = 1'b1; IOCTL_ADDR = a[k]; IOCTL_DOUT = d[k];
      tick();
      tests++;
      if (IOCTL_WAIT !== (k >= 2)) begin
        fails++;
        $display("FAIL bp_wait_%0d: WAIT=%b, wanted %b", k, IOCTL_WAIT, k >= 2);
      end
    end
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'h0005; IOCTL_DOUT = 8'h55;
    tick();
    tests++;
    if (ROMINIT_ERR !== 1'b1 || IOCTL_WAIT !== 1'b1) begin
      fails++;
      $display("FAIL bp_overflow: err=%b wait=%b, wanted 1/1", ROMINIT_ERR, IOCTL_WAIT);
    end
    IOCTL_WR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ROMINIT_VALID !== 1'b1 || ROMINIT_DATA !== d[0] || ROMINIT_ADDR !== o[0] ||
          ROMINIT_SEL !== s[0]) unstable++;
      tick();
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL bp_stall_stable: %0d unstable cycles, wanted 0", unstable);
    end
    ROMINIT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ROMINIT_VALID !== 1'b1 || ROMINIT_SEL !== s[k] || ROMINIT_ADDR !== o[k] ||
          ROMINIT_DATA !== d[k]) begin
        fails++;
        $display("FAIL bp_order_%0d: valid=%b sel=%b addr=%h data=%h, wanted 1 %b %h %h",
                 k, ROMINIT_VALID, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, s[k], o[k], d[k]);
      end
      tick();
    end
    tests++;
    if (ROMINIT_VALID !== 1'b0 || ROMINIT_SEL !== 2'b00) begin
      fails++;
      $display("FAIL bp_empty: valid=%b sel=%b, wanted 0/00", ROMINIT_VALID, ROMINIT_SEL);
    end
    IOCTL_DOWNLOAD = 1'b0;
    wait_idle("bp");
  endtask

  task automatic test_out_of_range;
    ROMINIT_READY = 1'b1; IOCTL_DOWNLOAD = 1'b1;
    tick();
    tests++;
    if (ROMINIT_ERR !== 1'b0) begin
      fails++;
      $display("FAIL oor_err_clear: ERR=%b, wanted 0", ROMINIT_ERR);
    end
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'h3000; IOCTL_DOUT = 8'h5A;
    tick();
    IOCTL_WR = 1'b0;
    tests++;
    if (ROMINIT_VALID !== 1'b0 || ROMINIT_ERR !== 1'b1) begin
      fails++;
      $display("FAIL oor_drop: valid=%b err=%b, wanted 0/1", ROMINIT_VALID, ROMINIT_ERR);
    end
    IOCTL_DOWNLOAD = 1'b0;
    wait_idle("oor");
    tests++;
    if (ROMINIT_ERR !== 1'b1) begin
      fails++;
      $display("FAIL oor_sticky: ERR=%b, wanted 1", ROMINIT_ERR);
    end
  endtask

  task automatic test_drain;
    int bad;
    bad = 0;
    ROMINIT_READY = 1'b0; IOCTL_DOWNLOAD = 1'b1;
    tick();
    tests++;
    if (ROMINIT_ERR !== 1'b0) begin
      fails++;
      $display("FAIL drain_err_clear: ERR=%b, wanted 0", ROMINIT_ERR);
    end
    for (int k = 0; k < 3; k++) begin
      IOCTL_WR = 1'b1; IOCTL_ADDR = 25'(16'h1100 + k); IOCTL_DOUT = 8'(8'hC0 + k);
      tick();
    end
    IOCTL_WR = 1'b0; IOCTL_DOWNLOAD = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) IOCTL_DOWNLOAD = 1'b1;
      if (IOCTL_WAIT !== 1'b1 || ROMINIT_BUSY !== 1'b1 || ROMINIT_DATA !== 8'hC0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL drain_hold: %0d cycles without WAIT/BUSY/stable head, wanted 0", bad);
    end
    ROMINIT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ROMINIT_VALID !== 1'b1 || ROMINIT_SEL !== 2'b10 || ROMINIT_ADDR !== 13'(13'h0100 + k) ||
          ROMINIT_DATA !== 8'(8'hC0 + k)) begin
        fails++;
        $display("FAIL drain_xfer_%0d: valid=%b sel=%b addr=%h data=%h, wanted 1 10 %h %h",
                 k, ROMINIT_VALID, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, 13'h0100 + k, 8'hC0 + k);
      end
      tick();
    end
    tests++;
    if (ROMINIT_VALID !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: VALID=%b, wanted 0", ROMINIT_VALID);
    end
    wait_idle("drain");
    tick();
    tests++;
    if (ROMINIT_BUSY !== 1'b1 || IOCTL_WAIT !== 1'b0) begin
      fails++;
      $display("FAIL drain_held_start: busy=%b wait=%b, wanted 1/0", ROMINIT_BUSY, IOCTL_WAIT);
    end
  endtask

  task automatic test_reset_mid_load;
    ROMINIT_READY = 1'b0;
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'h0100; IOCTL_DOUT = 8'h77; tick();
    IOCTL_ADDR = 25'h0101; IOCTL_DOUT = 8'h88; tick();
    IOCTL_ADDR = 25'h3001; tick();
    IOCTL_WR = 1'b0;
    RESET = 1'b1;
    tick();
    tests++;
    if ({ROMINIT_VALID, IOCTL_WAIT, ROMINIT_BUSY, ROMINIT_ERR, ROMINIT_DONE} !== 6'd0) begin
      fails++;
      $display("FAIL rstmid_clear: valid/wait/busy/err/done=%b, wanted 000000",
               {ROMINIT_VALID, IOCTL_WAIT, ROMINIT_BUSY, ROMINIT_ERR, ROMINIT_DONE});
    end
    RESET = 1'b0;
    ROMINIT_READY = 1'b1;
    tick();
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'h0200; IOCTL_DOUT = 8'h99;
    tick();
    IOCTL_WR = 1'b0;
    tests++;
    if (ROMINIT_VALID !== 1'b1 || ROMINIT_DATA !== 8'h99 || ROMINIT_ADDR !== 13'h0200) begin
      fails++;
      $display("FAIL rstmid_fresh: valid=%b addr=%h data=%h, wanted 1 0200 99",
               ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA);
    end
    tick();
    tests++;
    if (ROMINIT_VALID !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_no_stale: VALID=%b data=%h, wanted 0", ROMINIT_VALID, ROMINIT_DATA);
    end
    IOCTL_DOWNLOAD = 1'b0;
    wait_idle("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_wrong_index();
    test_backpressure();
    test_out_of_range();
    test_drain();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
